// File: rtl/spi_reg_bank_pkg.sv
// rtl/spi_reg_bank_pkg.sv - shared types and helpers for the SPI register bank
package spi_reg_bank_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DONE   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Frame = R/W bit + address field + data field, MSB first.
    function automatic int frame_len(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync2.sv
// rtl/spi_sync2.sv - two-flop synchroniser with configurable reset value
//
// Ports: clk, rst (sync active-high), d (asynchronous input),
//        q (synchronised output, RST_VAL while in reset).
module spi_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            q      <= RST_VAL;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - SPI mode-0 slave writing a small bank of registers
//
// Ports: clk, rst (sync active-high); sclk_raw/mosi_raw/cs_n_raw (async SPI bus);
//        miso, miso_oe (serial read data and its enable);
//        regs (flat bus, register i at [i*DATA_W +: DATA_W]);
//        wr_stb (per-register one-cycle write pulse); frame_err (discarded-frame pulse).
// Optional feature: define SPI_REG_BANK_READBACK_EN to enable register read-back on
// miso; otherwise miso/miso_oe are tied low and reads complete silently.
module spi_reg_bank
    import spi_reg_bank_pkg::*;
#(
    parameter int                NUM_REGS = 5,
    parameter int                ADDR_W   = 7,
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk_raw,
    input  logic                       mosi_raw,
    input  logic                       cs_n_raw,
    output logic                       miso,
    output logic                       miso_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs,
    output logic [NUM_REGS-1:0]        wr_stb,
    output logic                       frame_err
);

    localparam int                FRAME_LEN  = frame_len(ADDR_W, DATA_W);
    localparam int                CNT_W      = $clog2(FRAME_LEN + 1);
    localparam logic [ADDR_W:0]   NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

    logic cs_s, sclk_s, mosi_s;
    logic sclk_d, cs_d;
    logic sclk_rise, cs_rise;
    logic [1:0] vld_q;
    logic armed_q;

    state_t state_q, state_d, from_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [FRAME_LEN-1:0] sr_q;
    logic [DATA_W-1:0]    regs_q [NUM_REGS];

    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              addr_ok;
    logic              in_commit;
    logic              commit_wr;

    spi_sync2 #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst(rst), .d(cs_n_raw), .q(cs_s));
    spi_sync2 #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d(sclk_raw), .q(sclk_s));
    spi_sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d(mosi_raw), .q(mosi_s));

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_d <= 1'b0;
            cs_d   <= 1'b1;
            vld_q  <= 2'b00;
        end else begin
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
            vld_q  <= {vld_q[0], 1'b1};
        end
    end

    assign sclk_rise = sclk_s & ~sclk_d;
    assign cs_rise   = cs_s & ~cs_d;

    // armed_q records that cs_n has been genuinely high since the last frame start
    // (vld_q masks the synchroniser reset value). Starting on "armed and cs_n low"
    // rather than on a one-cycle edge keeps a fall that lands during COMMIT, and
    // ignores a frame that was already in flight when reset was released.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q <= 1'b0;
        end else if (state_q == IDLE && state_d == SHIFT) begin
            armed_q <= 1'b0;
        end else if (cs_s && vld_q[1]) begin
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == COMMIT) begin
            state_d = IDLE;
        end else if (cs_rise) begin
            state_d = COMMIT;
        end else begin
            case (state_q)
                IDLE:    if (armed_q && !cs_s) state_d = SHIFT;
                SHIFT:   if (sclk_rise && cnt_q == CNT_W'(FRAME_LEN - 1)) state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            from_q  <= IDLE;
        end else begin
            state_q <= state_d;
            if (state_d == COMMIT) from_q <= state_q;
        end
    end

    // Shift only in SHIFT, so sclk edges in DONE leave the captured frame intact.
    always_ff @(posedge clk) begin
        if (rst || state_q == IDLE) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else if (state_q == SHIFT && sclk_rise) begin
            sr_q <= {sr_q[FRAME_LEN-2:0], mosi_s};
            if (cnt_q != CNT_W'(FRAME_LEN)) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign rw        = sr_q[FRAME_LEN-1];
    assign addr      = sr_q[DATA_W +: ADDR_W];
    assign data      = sr_q[DATA_W-1:0];
    assign addr_ok   = {1'b0, addr} < NUM_REGS_L;
    assign in_commit = (state_q == COMMIT);
    assign commit_wr = ~rst & in_commit & (from_q == DONE) & (rw == RW_WRITE) & addr_ok;
    assign frame_err = ~rst & in_commit &
                       ((from_q == SHIFT) | ((from_q == DONE) & (rw == RW_WRITE) & ~addr_ok));

    always_comb begin
        wr_stb = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (commit_wr && addr == ADDR_W'(i)) wr_stb[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RST_VAL;
        end else if (commit_wr) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (addr == ADDR_W'(i)) regs_q[i] <= data;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
        assign regs[g*DATA_W +: DATA_W] = regs_q[g];
    end

`ifdef SPI_REG_BANK_READBACK_EN
    logic              sclk_fall;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] out_sr;
    logic              oe_q;

    assign sclk_fall = ~sclk_s & sclk_d;

    // While the last address bit is fresh, the address sits in the low bits of sr_q.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sr_q[ADDR_W-1:0] == ADDR_W'(i)) rd_data = regs_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state_q == IDLE || state_q == COMMIT) begin
            out_sr <= '0;
            oe_q   <= 1'b0;
        end else if (sclk_fall) begin
            if (state_q == SHIFT && cnt_q == CNT_W'(1 + ADDR_W) && sr_q[ADDR_W] == RW_READ) begin
                out_sr <= rd_data;
                oe_q   <= 1'b1;
            end else if (oe_q) begin
                out_sr <= out_sr << 1;
            end
        end
    end

    assign miso    = out_sr[DATA_W-1];
    assign miso_oe = oe_q;
`else
    assign miso    = 1'b0;
    assign miso_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb/tb_spi_reg_bank.sv - directed self-checking bench for spi_reg_bank
module tb_spi_reg_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk, mosi, cs0, cs1;
    logic        miso, miso_oe, frame_err;
    logic [39:0] regs;
    logic [4:0]  wr_stb;
    logic        miso16, miso_oe16, frame_err16;
    logic [47:0] regs16;
    logic [2:0]  wr_stb16;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int stb_cnt = 0, err_cnt = 0, drv_cnt = 0, stb16_cnt = 0, err16_cnt = 0;
    logic [4:0]  stb_val;
    logic [39:0] regs_at_stb;
    logic [2:0]  stb16_val;

    logic [15:0] rd;
    logic        oe7, oe8, oe_end;

    always #5 clk = ~clk;

    spi_reg_bank dut (
        .clk(clk), .rst(rst), .sclk_raw(sclk), .mosi_raw(mosi), .cs_n_raw(cs0),
        .miso(miso), .miso_oe(miso_oe), .regs(regs), .wr_stb(wr_stb), .frame_err(frame_err)
    );

    spi_reg_bank #(.NUM_REGS(3), .ADDR_W(7), .DATA_W(16)) dut16 (
        .clk(clk), .rst(rst), .sclk_raw(sclk), .mosi_raw(mosi), .cs_n_raw(cs1),
        .miso(miso16), .miso_oe(miso_oe16), .regs(regs16), .wr_stb(wr_stb16),
        .frame_err(frame_err16)
    );

    always @(negedge clk) begin
        if (wr_stb != 5'b0) begin
            stb_cnt++;
            stb_val     = wr_stb;
            regs_at_stb = regs;
        end
        if (frame_err) err_cnt++;
        if (miso || miso_oe) drv_cnt++;
        if (wr_stb16 != 3'b0) begin
            stb16_cnt++;
            stb16_val = wr_stb16;
        end
        if (frame_err16) err16_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        stb_cnt = 0; err_cnt = 0; drv_cnt = 0; stb16_cnt = 0; err16_cnt = 0;
        stb_val = '0; regs_at_stb = '0; stb16_val = '0;
    endtask

    task automatic bit_out(input logic b, output logic m, output logic oe);
        mosi = b;
        #60 sclk = 1'b1;
        m  = miso;
        oe = miso_oe;
        #60 sclk = 1'b0;
    endtask

    // Master side of one frame: nbits bits MSB first, then extra idle sclk pulses,
    // then cs_n high for gap ns. Collects miso samples into rd.
    task automatic xfer(input logic [31:0] frame, input int nbits, input int extra,
                        input bit sel16, input int gap);
        logic m, oe;
        rd = '0; oe7 = 1'b0; oe8 = 1'b0; oe_end = 1'b0;
        if (sel16) cs1 = 1'b0; else cs0 = 1'b0;
        #60;
        for (int i = 0; i < nbits; i++) begin
            bit_out(frame[nbits-1-i], m, oe);
            rd = {rd[14:0], m};
            if (i == 7) oe7 = oe;
            if (i == 8) oe8 = oe;
        end
        for (int i = 0; i < extra; i++) begin
            #60 sclk = 1'b1;
            #60 sclk = 1'b0;
        end
        oe_end = miso_oe;
        #60;
        cs0 = 1'b1;
        cs1 = 1'b1;
        #(gap);
    endtask

    initial begin
        logic m, oe;
        rst = 1'b1; sclk = 1'b0; mosi = 1'b0; cs0 = 1'b1; cs1 = 1'b1;
        #2;
        #50 rst = 1'b0;
        #50;
        chk("reset_regs",   regs,      40'h0);
        chk("reset_wr_stb", wr_stb,    5'b0);
        chk("reset_err",    frame_err, 1'b0);
        chk("reset_miso",   miso,      1'b0);
        chk("reset_oe",     miso_oe,   1'b0);

        clr();
        xfer(32'h8155, 16, 0, 1'b0, 100);
        chk("wr1_regs",     regs,              40'h00_00_00_55_00);
        chk("wr1_stb_cnt",  stb_cnt,           1);
        chk("wr1_stb_val",  stb_val,           5'b00010);
        chk("wr1_old_val",  regs_at_stb[15:8], 8'h00);
        chk("wr1_err",      err_cnt,           0);

        clr();
        xfer(32'h85AA, 16, 0, 1'b0, 100);
        chk("oor_err",      err_cnt, 1);
        chk("oor_stb",      stb_cnt, 0);
        chk("oor_regs",     regs,    40'h00_00_00_55_00);

        clr();
        xfer(32'h843C, 16, 0, 1'b0, 100);
        chk("wr4_regs",     regs,    40'h3C_00_00_55_00);
        chk("wr4_stb_val",  stb_val, 5'b10000);

        clr();
        xfer(32'h0000_0102, 9, 0, 1'b0, 100);
        chk("short_err",    err_cnt, 1);
        chk("short_stb",    stb_cnt, 0);
        chk("short_regs",   regs,    40'h3C_00_00_55_00);

        clr();
        xfer(32'h0400, 16, 0, 1'b0, 100);
        chk("rd4_err",      err_cnt, 0);
        chk("rd4_stb",      stb_cnt, 0);
        chk("rd4_regs",     regs,    40'h3C_00_00_55_00);
`ifdef SPI_REG_BANK_READBACK_EN
        chk("rd4_data",     rd[7:0], 8'h3C);
        chk("rd4_oe_bit8",  oe7,     1'b0);
        chk("rd4_oe_bit9",  oe8,     1'b1);
        chk("rd4_oe_end",   oe_end,  1'b1);
        chk("rd4_oe_after", miso_oe, 1'b0);
`else
        chk("rd4_quiet",    drv_cnt, 0);
`endif

        clr();
        xfer(32'h7F00, 16, 0, 1'b0, 100);
        chk("rd_oor_err",   err_cnt, 0);
`ifdef SPI_REG_BANK_READBACK_EN
        chk("rd_oor_data",  rd[7:0], 8'h00);
`else
        chk("rd_oor_quiet", drv_cnt, 0);
`endif

        clr();
        xfer(32'h8011, 16, 0, 1'b0, 40);
        xfer(32'h8122, 16, 0, 1'b0, 100);
        chk("b2b_regs",     regs,    40'h3C_00_00_22_11);
        chk("b2b_stb_cnt",  stb_cnt, 2);
        chk("b2b_err",      err_cnt, 0);

        clr();
        cs0 = 1'b0;
        #60;
        for (int i = 0; i < 12; i++) bit_out(((16'h8377 >> (15 - i)) & 16'h1) != 0, m, oe);
        rst = 1'b1;
        #30 rst = 1'b0;
        for (int i = 12; i < 16; i++) bit_out(((16'h8377 >> (15 - i)) & 16'h1) != 0, m, oe);
        #60 cs0 = 1'b1;
        #100;
        chk("abort_regs",   regs,    40'h0);
        chk("abort_stb",    stb_cnt, 0);
        chk("abort_err",    err_cnt, 0);
        xfer(32'h8201, 16, 0, 1'b0, 100);
        chk("post_rst_regs", regs,    40'h00_00_01_00_00);
        chk("post_rst_stb",  stb_val, 5'b00100);
        chk("post_rst_cnt",  stb_cnt, 1);

        clr();
        xfer(32'h0081_BEEF, 24, 10, 1'b1, 100);
        chk("w16_regs",     regs16,    48'h0000_BEEF_0000);
        chk("w16_stb_cnt",  stb16_cnt, 1);
        chk("w16_stb_val",  stb16_val, 3'b010);
        chk("w16_err",      err16_cnt, 0);
        chk("w16_other",    regs,      40'h00_00_01_00_00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
